// File: rtl/shields_array_object_if.sv
// ============================================================================
// Module   : shields_array_object_if
// Brief    : Pixel, collision and status bundle between renderer and shield row.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface shields_array_object_if #(
    parameter int NUM_SHIELDS = 4,
    parameter int HEALTH_W    = 3
);
    localparam int IDX_W = (NUM_SHIELDS > 1) ? $clog2(NUM_SHIELDS) : 1;

    logic signed [10:0]      pixelX;
    logic signed [10:0]      pixelY;
    logic                    startOfFrame;
    logic                    collision;
    logic                    restore;
    logic [10:0]             offsetX;
    logic [10:0]             offsetY;
    logic                    InsideRectangle;
    logic [IDX_W-1:0]        shieldIndex;
    logic [HEALTH_W-1:0]     shieldHealth;
    logic [NUM_SHIELDS-1:0]  shieldsAlive;
    logic                    allDestroyed;

    modport master (
        output pixelX, pixelY, startOfFrame, collision, restore,
        input  offsetX, offsetY, InsideRectangle, shieldIndex, shieldHealth,
               shieldsAlive, allDestroyed
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, collision, restore,
        output offsetX, offsetY, InsideRectangle, shieldIndex, shieldHealth,
               shieldsAlive, allDestroyed
    );
endinterface

`default_nettype wire

// File: rtl/shields_array_object.sv
// ============================================================================
// Module   : shields_array_object
// Brief    : Row of NUM_SHIELDS shields: pixel hit-test plus per-frame damage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shields_array_object #(
    parameter int NUM_SHIELDS     = 4,
    parameter int FIRST_TOPLEFT_X = 16,
    parameter int TOPLEFT_Y       = 176,
    parameter int SPACING_X       = 160,
    parameter int OBJECT_WIDTH_X  = 64,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int MAX_HEALTH      = 4,
    parameter int HEALTH_W        = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    shields_array_object_if.slave bus
);
    localparam int IDX_W = (NUM_SHIELDS > 1) ? $clog2(NUM_SHIELDS) : 1;
    localparam logic [HEALTH_W-1:0] C_FULL = HEALTH_W'(MAX_HEALTH);

    logic [HEALTH_W-1:0]    health_q [NUM_SHIELDS];
    logic [HEALTH_W-1:0]    health_d [NUM_SHIELDS];
    logic [NUM_SHIELDS-1:0] pending_q, pending_d;
    logic                   inside_q, inside_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [10:0]            offset_x_q, offset_x_d;
    logic [10:0]            offset_y_q, offset_y_d;
    logic [HEALTH_W-1:0]    shield_health_q, shield_health_d;
    logic [NUM_SHIELDS-1:0] alive_q, alive_d;
    logic                   all_destroyed_q, all_destroyed_d;

    int px, py, left_x;

    // Hit-test: scan upward so the lowest live index claims overlapping pixels.
    always_comb begin
        inside_d        = 1'b0;
        index_d         = '0;
        offset_x_d      = '0;
        offset_y_d      = '0;
        shield_health_d = '0;
        left_x          = 0;
        px              = int'(bus.pixelX);
        py              = int'(bus.pixelY);
        for (int i = 0; i < NUM_SHIELDS; i++) begin
            left_x = FIRST_TOPLEFT_X + i * SPACING_X;
            if (!inside_d && (health_q[i] != '0) &&
                (px >= left_x) && (px < left_x + OBJECT_WIDTH_X) &&
                (py >= TOPLEFT_Y) && (py < TOPLEFT_Y + OBJECT_HEIGHT_Y)) begin
                inside_d        = 1'b1;
                index_d         = IDX_W'(i);
                offset_x_d      = 11'(px - left_x);
                offset_y_d      = 11'(py - TOPLEFT_Y);
                shield_health_d = health_q[i];
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_SHIELDS; i++) begin
            health_d[i] = health_q[i];
            alive_d[i]  = (health_q[i] != '0);
        end
        all_destroyed_d = 1'b1;
        for (int i = 0; i < NUM_SHIELDS; i++) begin
            if (health_q[i] != '0) all_destroyed_d = 1'b0;
        end

        if (bus.restore) begin
            pending_d = '0;
            for (int i = 0; i < NUM_SHIELDS; i++) health_d[i] = C_FULL;
        end else begin
            if (bus.startOfFrame) begin
                for (int i = 0; i < NUM_SHIELDS; i++) begin
                    if (pending_q[i] && (health_q[i] != '0))
                        health_d[i] = health_q[i] - HEALTH_W'(1);
                end
                pending_d = '0;
            end
            // A hit landing on the frame boundary is kept for the next frame.
            if (bus.collision && inside_q) begin
                for (int i = 0; i < NUM_SHIELDS; i++) begin
                    if (index_q == IDX_W'(i)) pending_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SHIELDS; i++) health_q[i] <= C_FULL;
            pending_q       <= '0;
            inside_q        <= 1'b0;
            index_q         <= '0;
            offset_x_q      <= '0;
            offset_y_q      <= '0;
            shield_health_q <= '0;
            alive_q         <= '1;
            all_destroyed_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SHIELDS; i++) health_q[i] <= health_d[i];
            pending_q       <= pending_d;
            inside_q        <= inside_d;
            index_q         <= index_d;
            offset_x_q      <= offset_x_d;
            offset_y_q      <= offset_y_d;
            shield_health_q <= shield_health_d;
            alive_q         <= alive_d;
            all_destroyed_q <= all_destroyed_d;
        end
    end

    assign bus.InsideRectangle = inside_q;
    assign bus.shieldIndex     = index_q;
    assign bus.offsetX         = offset_x_q;
    assign bus.offsetY         = offset_y_q;
    assign bus.shieldHealth    = shield_health_q;
    assign bus.shieldsAlive    = alive_q;
    assign bus.allDestroyed    = all_destroyed_q;

endmodule

`default_nettype wire

// File: tb/tb_shields_array_object.sv
// ============================================================================
// Module   : tb_shields_array_object
// Brief    : Directed stimulus against a frame-level model of the shield row.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shields_array_object;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shields_array_object_if #(.NUM_SHIELDS(4), .HEALTH_W(3)) bus ();

    shields_array_object dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 1'b0;

    // Model: health/pending per shield plus what the outputs must show next.
    int m_health [4];
    bit m_pend   [4];
    bit e_inside;
    int e_idx, e_offx, e_offy, e_hp;
    logic [3:0] e_alive;
    bit e_all;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    always @(posedge clk) begin : model
        int nh [4];
        bit np [4];
        int px, py, lx;
        bit f;
        int fi, fx, fy, fh;
        logic [3:0] al;
        if (reset) begin
            for (int k = 0; k < 4; k++) begin m_health[k] <= 4; m_pend[k] <= 1'b0; end
            e_inside <= 1'b0; e_idx <= 0; e_offx <= 0; e_offy <= 0; e_hp <= 0;
            e_alive <= 4'hF; e_all <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin nh[k] = m_health[k]; np[k] = m_pend[k]; end
            if (bus.restore) begin
                for (int k = 0; k < 4; k++) begin nh[k] = 4; np[k] = 1'b0; end
            end else begin
                if (bus.startOfFrame)
                    for (int k = 0; k < 4; k++) begin
                        if (np[k] && nh[k] > 0) nh[k] = nh[k] - 1;
                        np[k] = 1'b0;
                    end
                if (bus.collision && e_inside) np[e_idx] = 1'b1;
            end
            px = int'(bus.pixelX);
            py = int'(bus.pixelY);
            f = 1'b0; fi = 0; fx = 0; fy = 0; fh = 0;
            for (int k = 3; k >= 0; k--) begin
                lx = 16 + 160 * k;
                if (m_health[k] > 0 && px >= lx && px <= lx + 63 && py >= 176 && py <= 207) begin
                    f = 1'b1; fi = k; fx = px - lx; fy = py - 176; fh = m_health[k];
                end
            end
            for (int k = 0; k < 4; k++) al[k] = (m_health[k] != 0);
            for (int k = 0; k < 4; k++) begin m_health[k] <= nh[k]; m_pend[k] <= np[k]; end
            e_inside <= f; e_idx <= fi; e_offx <= fx; e_offy <= fy; e_hp <= fh;
            e_alive <= al; e_all <= (al == 4'h0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_inside", 32'(bus.InsideRectangle), 32'(e_inside));
            check("model_index",  32'(bus.shieldIndex),     32'(e_idx));
            check("model_offx",   32'(bus.offsetX),         32'(e_offx));
            check("model_offy",   32'(bus.offsetY),         32'(e_offy));
            check("model_health", 32'(bus.shieldHealth),    32'(e_hp));
            check("model_alive",  32'(bus.shieldsAlive),    32'(e_alive));
            check("model_alldes", 32'(bus.allDestroyed),    32'(e_all));
        end
    end

    task automatic pix(input int x, input int y);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        @(negedge clk);
    endtask

    task automatic hit(input int k);
        pix(48 + 160 * k, 190);
        bus.collision = 1'b1;
        @(negedge clk);
        bus.collision = 1'b0;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.pixelX = '0; bus.pixelY = '0;
        bus.startOfFrame = 1'b0; bus.collision = 1'b0; bus.restore = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_inside", 32'(bus.InsideRectangle), 32'd0);
        check("rst_alive",  32'(bus.shieldsAlive),    32'hF);
        check("rst_alldes", 32'(bus.allDestroyed),    32'd0);
        reset = 1'b0;

        // Geometry
        pix(16, 176);
        check("p16_inside", 32'(bus.InsideRectangle), 32'd1);
        check("p16_index",  32'(bus.shieldIndex),     32'd0);
        check("p16_offx",   32'(bus.offsetX),         32'd0);
        check("p16_health", 32'(bus.shieldHealth),    32'd4);
        pix(79, 207);
        check("p79_offx", 32'(bus.offsetX), 32'd63);
        check("p79_offy", 32'(bus.offsetY), 32'd31);
        pix(80, 176);
        check("p80_inside", 32'(bus.InsideRectangle), 32'd0);
        pix(336, 190);
        check("p336_index", 32'(bus.shieldIndex), 32'd2);
        check("p336_offx",  32'(bus.offsetX),     32'd0);
        check("p336_offy",  32'(bus.offsetY),     32'd14);
        pix(15, 176);
        check("p15_inside", 32'(bus.InsideRectangle), 32'd0);
        pix(16, 208);
        check("y208_inside", 32'(bus.InsideRectangle), 32'd0);

        // Repeat hits in one frame count once
        hit(1); hit(1); hit(1);
        frame();
        pix(208, 190);
        check("s1_health3", 32'(bus.shieldHealth), 32'd3);
        pix(48, 190);
        check("s0_health4", 32'(bus.shieldHealth), 32'd4);

        // Destroy shield 0 over four frames
        for (int n = 0; n < 4; n++) begin hit(0); frame(); end
        check("s0_dead_alive", 32'(bus.shieldsAlive), 32'b1110);
        pix(16, 176);
        check("s0_dead_inside", 32'(bus.InsideRectangle), 32'd0);
        hit(0);
        frame();
        check("s0_extra_alive", 32'(bus.shieldsAlive), 32'b1110);

        // Destroy the rest
        for (int n = 0; n < 4; n++) begin hit(1); hit(2); hit(3); frame(); end
        check("all_destroyed", 32'(bus.allDestroyed), 32'd1);
        check("all_alive0",    32'(bus.shieldsAlive), 32'd0);
        bus.restore = 1'b1;
        @(negedge clk);
        bus.restore = 1'b0;
        @(negedge clk);
        check("restore_alive",  32'(bus.shieldsAlive), 32'hF);
        check("restore_alldes", 32'(bus.allDestroyed), 32'd0);

        // Restore beats a same-cycle frame update and a pending hit
        hit(2);
        pix(368, 190);
        bus.collision = 1'b1; bus.restore = 1'b1; bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.collision = 1'b0; bus.restore = 1'b0; bus.startOfFrame = 1'b0;
        @(negedge clk);
        frame();
        pix(368, 190);
        check("s2_after_restore", 32'(bus.shieldHealth), 32'd4);
        pix(208, 190);
        check("s1_after_restore", 32'(bus.shieldHealth), 32'd4);

        // Reset discards a pending hit
        hit(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        frame();
        pix(528, 190);
        check("s3_after_reset_inside", 32'(bus.InsideRectangle), 32'd1);
        check("s3_after_reset_health", 32'(bus.shieldHealth),    32'd4);

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

`default_nettype wire
